// File: rtl/borrow101_down_counter_pkg.sv
// ============================================================================
// Module  : borrow101_down_counter_pkg
// Brief   : Shared defaults for the mod-101 down counter and its BCD path.
// Revision: 1.0
// ============================================================================
`default_nettype none

package borrow101_down_counter_pkg;

    localparam int WIDTH_DEF   = 7;
    localparam int MODULUS_DEF = 101;
    localparam int MAXVAL_DEF  = MODULUS_DEF - 1;
    localparam int BCD_W       = 4;
    localparam int BCD_BIN_W   = 10;

endpackage

`default_nettype wire

// File: rtl/borrow101_down_counter_bin2bcd.sv
// ============================================================================
// Module  : bin2bcd_999
// Brief   : Combinational binary (0..999) to three-digit BCD converter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bin2bcd_999
    import borrow101_down_counter_pkg::*;
(
    input  logic [BCD_BIN_W-1:0] bin_i,
    output logic [BCD_W-1:0]     hund_o,
    output logic [BCD_W-1:0]     tens_o,
    output logic [BCD_W-1:0]     units_o
);

    logic [BCD_W-1:0] w_hund;
    logic [6:0]       w_rem;
    logic [BCD_W-1:0] w_tens;
    logic [BCD_W-1:0] w_units;

    // Remainders are bounded (<100, <10), so the narrow casts lose nothing.
    always_comb begin
        w_hund  = 4'(bin_i / 10'd100);
        w_rem   = 7'(bin_i - 10'd100 * {6'd0, w_hund});
        w_tens  = 4'(w_rem / 7'd10);
        w_units = 4'(w_rem - 7'd10 * {3'd0, w_tens});
    end

    assign hund_o  = w_hund;
    assign tens_o  = w_tens;
    assign units_o = w_units;

endmodule

`default_nettype wire

// File: rtl/borrow101_down_counter.sv
// ============================================================================
// Module  : borrow101_down_counter
// Brief   : Loadable modulo-MODULUS down counter with borrow pulse and BCD out.
// Revision: 1.0
// ============================================================================
`default_nettype none

module borrow101_down_counter
    import borrow101_down_counter_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int MODULUS = MODULUS_DEF
)(
    input  logic             sysClk,
    input  logic             sysRst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] loadValue,
    output logic [WIDTH-1:0] counter,
    output logic             zero,
    output logic             borrow,
    output logic [BCD_W-1:0] bcdHund,
    output logic [BCD_W-1:0] bcdTens,
    output logic [BCD_W-1:0] bcdUnits
);

    localparam logic [WIDTH-1:0] MAXVAL   = WIDTH'(MODULUS - 1);
    localparam logic [BCD_W-1:0] RST_HUND = BCD_W'((MODULUS - 1) / 100);
    localparam logic [BCD_W-1:0] RST_TENS = BCD_W'(((MODULUS - 1) / 10) % 10);
    localparam logic [BCD_W-1:0] RST_UNIT = BCD_W'((MODULUS - 1) % 10);

    generate
        if (MODULUS < 2) begin : g_bad_modulus
            $error("borrow101_down_counter: MODULUS must be at least 2");
        end
        if ((MODULUS - 1) > ((1 << WIDTH) - 1)) begin : g_bad_width
            $error("borrow101_down_counter: MODULUS-1 does not fit in WIDTH");
        end
        if (WIDTH > BCD_BIN_W) begin : g_bad_bcd
            $error("borrow101_down_counter: WIDTH exceeds BCD converter range");
        end
    endgenerate

    logic [WIDTH-1:0] counter_q, counter_d;
    logic             borrow_q,  borrow_d;
    logic [BCD_W-1:0] hund_q, tens_q, units_q;
    logic [BCD_W-1:0] hund_d, tens_d, units_d;

    always_comb begin
        counter_d = counter_q;
        borrow_d  = 1'b0;
        if (load) begin
            counter_d = (loadValue > MAXVAL) ? MAXVAL : loadValue;
        end else if (en) begin
            if (counter_q == '0) begin
                counter_d = MAXVAL;
                borrow_d  = 1'b1;
            end else begin
                counter_d = counter_q - WIDTH'(1);
            end
        end
    end

    // Converting the next value keeps the digits aligned with counter.
    bin2bcd_999 u_bin2bcd (
        .bin_i   (BCD_BIN_W'(counter_d)),
        .hund_o  (hund_d),
        .tens_o  (tens_d),
        .units_o (units_d)
    );

    always_ff @(posedge sysClk) begin
        if (sysRst) begin
            counter_q <= MAXVAL;
            borrow_q  <= 1'b0;
            hund_q    <= RST_HUND;
            tens_q    <= RST_TENS;
            units_q   <= RST_UNIT;
        end else begin
            counter_q <= counter_d;
            borrow_q  <= borrow_d;
            hund_q    <= hund_d;
            tens_q    <= tens_d;
            units_q   <= units_d;
        end
    end

    assign counter  = counter_q;
    assign zero     = (counter_q == '0);
    assign borrow   = borrow_q;
    assign bcdHund  = hund_q;
    assign bcdTens  = tens_q;
    assign bcdUnits = units_q;

endmodule

`default_nettype wire

// File: tb/tb_borrow101_down_counter.sv
// ============================================================================
// Module  : tb_borrow101_down_counter
// Brief   : Directed self-checking bench, including a two-stage cascade.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_borrow101_down_counter;

    logic       clk;
    logic       rst;
    logic       en;
    logic       load;
    logic [6:0] load_val;
    logic [6:0] cnt0, cnt1;
    logic       zero0, zero1;
    logic       borrow0, borrow1;
    logic [3:0] hund0, tens0, units0;
    logic [3:0] hund1, tens1, units1;

    int total = 0;
    int bad   = 0;

    borrow101_down_counter dut (
        .sysClk    (clk),
        .sysRst    (rst),
        .en        (en),
        .load      (load),
        .loadValue (load_val),
        .counter   (cnt0),
        .zero      (zero0),
        .borrow    (borrow0),
        .bcdHund   (hund0),
        .bcdTens   (tens0),
        .bcdUnits  (units0)
    );

    borrow101_down_counter dut_stage1 (
        .sysClk    (clk),
        .sysRst    (rst),
        .en        (borrow0),
        .load      (1'b0),
        .loadValue (7'd0),
        .counter   (cnt1),
        .zero      (zero1),
        .borrow    (borrow1),
        .bcdHund   (hund1),
        .bcdTens   (tens1),
        .bcdUnits  (units1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; load = 1'b0; load_val = 7'd0;
        step();
        rst = 1'b0;
        total++; if (cnt0 !== 7'd100) begin bad++; $display("FAIL reset_counter got=%0d want=100", cnt0); end
        total++; if ({hund0, tens0, units0} !== 12'h100) begin bad++; $display("FAIL reset_bcd got=%h%h%h want=100", hund0, tens0, units0); end
        total++; if (borrow0 !== 1'b0) begin bad++; $display("FAIL reset_borrow got=%b want=0", borrow0); end
        total++; if (zero0 !== 1'b0) begin bad++; $display("FAIL reset_zero got=%b want=0", zero0); end
    endtask

    task automatic test_free_run();
        int exp_cnt;
        en = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            step();
            exp_cnt = 100 - i;
            total++; if (cnt0 !== 7'(exp_cnt)) begin bad++; $display("FAIL run_counter step=%0d got=%0d want=%0d", i, cnt0, exp_cnt); end
            total++; if ({hund0, tens0, units0} !== {4'(exp_cnt / 100), 4'((exp_cnt / 10) % 10), 4'(exp_cnt % 10)}) begin
                bad++; $display("FAIL run_bcd step=%0d got=%h%h%h want=%0d", i, hund0, tens0, units0, exp_cnt);
            end
            total++; if (zero0 !== (exp_cnt == 0)) begin bad++; $display("FAIL run_zero step=%0d got=%b want=%b", i, zero0, exp_cnt == 0); end
            total++; if (borrow0 !== 1'b0) begin bad++; $display("FAIL run_borrow step=%0d got=%b want=0", i, borrow0); end
        end
        step();
        total++; if (cnt0 !== 7'd100) begin bad++; $display("FAIL wrap_counter got=%0d want=100", cnt0); end
        total++; if (borrow0 !== 1'b1) begin bad++; $display("FAIL wrap_borrow got=%b want=1", borrow0); end
        total++; if ({hund0, tens0, units0} !== 12'h100) begin bad++; $display("FAIL wrap_bcd got=%h%h%h want=100", hund0, tens0, units0); end
        step();
        total++; if (cnt0 !== 7'd99) begin bad++; $display("FAIL after_wrap_counter got=%0d want=99", cnt0); end
        total++; if (borrow0 !== 1'b0) begin bad++; $display("FAIL borrow_one_cycle got=%b want=0", borrow0); end
        en = 1'b0;
        step();
        total++; if (cnt0 !== 7'd99) begin bad++; $display("FAIL idle_hold got=%0d want=99", cnt0); end
    endtask

    task automatic test_load_priority();
        load = 1'b1; load_val = 7'd37; en = 1'b0;
        step();
        total++; if (cnt0 !== 7'd37) begin bad++; $display("FAIL load_37 got=%0d want=37", cnt0); end
        en = 1'b1; load_val = 7'd5;
        step();
        total++; if (cnt0 !== 7'd5) begin bad++; $display("FAIL load_over_en got=%0d want=5", cnt0); end
        total++; if ({hund0, tens0, units0} !== 12'h005) begin bad++; $display("FAIL load_bcd got=%h%h%h want=005", hund0, tens0, units0); end
        load_val = 7'd127;
        step();
        total++; if (cnt0 !== 7'd100) begin bad++; $display("FAIL load_clamp got=%0d want=100", cnt0); end
        load_val = 7'd101;
        step();
        total++; if (cnt0 !== 7'd100) begin bad++; $display("FAIL load_clamp_101 got=%0d want=100", cnt0); end
        load = 1'b0; en = 1'b0;
    endtask

    task automatic test_load_at_zero();
        load = 1'b1; load_val = 7'd0; en = 1'b0;
        step();
        total++; if (zero0 !== 1'b1) begin bad++; $display("FAIL load_zero_flag got=%b want=1", zero0); end
        en = 1'b1; load_val = 7'd42;
        step();
        total++; if (cnt0 !== 7'd42) begin bad++; $display("FAIL load_at_zero got=%0d want=42", cnt0); end
        total++; if (borrow0 !== 1'b0) begin bad++; $display("FAIL load_at_zero_borrow got=%b want=0", borrow0); end
        total++; if ({hund0, tens0, units0} !== 12'h042) begin bad++; $display("FAIL load_at_zero_bcd got=%h%h%h want=042", hund0, tens0, units0); end
        load = 1'b0; en = 1'b0;
    endtask

    task automatic test_mid_reset();
        load = 1'b1; load_val = 7'd1; en = 1'b1;
        step();
        load = 1'b0;
        step();
        total++; if (cnt0 !== 7'd0) begin bad++; $display("FAIL mid_reset_reach0 got=%0d want=0", cnt0); end
        rst = 1'b1;
        step();
        total++; if (cnt0 !== 7'd100) begin bad++; $display("FAIL mid_reset_counter got=%0d want=100", cnt0); end
        total++; if (borrow0 !== 1'b0) begin bad++; $display("FAIL mid_reset_borrow got=%b want=0", borrow0); end
        rst = 1'b0;
        step();
        total++; if (cnt0 !== 7'd99) begin bad++; $display("FAIL mid_reset_resume got=%0d want=99", cnt0); end
        total++; if ({hund0, tens0, units0} !== 12'h099) begin bad++; $display("FAIL mid_reset_bcd got=%h%h%h want=099", hund0, tens0, units0); end
        en = 1'b0;
    endtask

    task automatic test_cascade();
        rst = 1'b1; en = 1'b0; load = 1'b0;
        step();
        rst = 1'b0; en = 1'b1;
        for (int k = 1; k <= 102; k++) begin
            step();
            if (k == 100) begin
                total++; if (cnt1 !== 7'd100) begin bad++; $display("FAIL cascade_early got=%0d want=100", cnt1); end
            end
            if (k == 101) begin
                total++; if (borrow0 !== 1'b1) begin bad++; $display("FAIL cascade_stage0_borrow got=%b want=1", borrow0); end
                total++; if (cnt1 !== 7'd100) begin bad++; $display("FAIL cascade_hold got=%0d want=100", cnt1); end
            end
            if (k == 102) begin
                total++; if (cnt1 !== 7'd99) begin bad++; $display("FAIL cascade_step got=%0d want=99", cnt1); end
                total++; if (borrow0 !== 1'b0) begin bad++; $display("FAIL cascade_borrow_clear got=%b want=0", borrow0); end
            end
        end
        en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; load = 1'b0; load_val = 7'd0;
        test_reset();
        test_free_run();
        test_load_priority();
        test_load_at_zero();
        test_mid_reset();
        test_cascade();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
